// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and command-word helper for the ADC SPI sequencer.
package adc_pkg;
  localparam int ADC_DATA_W         = 12;
  localparam int ADC_CH_W           = 3;
  localparam int ADC_FRAME_BITS     = 16;
  localparam int ADC_ADDR_FIRST_BIT = 3;
  localparam int ADC_DATA_FIRST_BIT = 5;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} adc_state_t;

  // Command word {2'b00, addr, 11'b0}: address lands in SCLK periods 3..5, MSB first.
  function automatic logic [ADC_FRAME_BITS-1:0] adc_cmd(input logic [ADC_CH_W-1:0] addr);
    logic [ADC_FRAME_BITS-1:0] w;
    w = '0;
    w[ADC_FRAME_BITS-ADC_ADDR_FIRST_BIT -: ADC_CH_W] = addr;
    return w;
  endfunction
endpackage

// File: rtl/adc_rate_timer.sv
// Free-running sample-rate divider; tick on the last count, held at zero while disabled.
module adc_rate_timer
  import adc_pkg::*;
#(
  parameter int SAMPLE_DIV = 1042
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en)       cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/adc_spi_sequencer.sv
// SPI master for the 8-channel 12-bit ADC: paces frames, sends the address, returns
// the previous frame's conversion with a one-cycle strobe and channel tag.
module adc_spi_sequencer
  import adc_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ADC_CH_W-1:0]   cfg_ch,
  input  logic                  cfg_scan,
  input  logic [ADC_CH_W-1:0]   cfg_scan_last,
  input  logic                  clr_overrun,
  output logic                  ADC_SCLK,
  output logic                  ADC_CS_N,
  output logic                  ADC_SADDR,
  input  logic                  ADC_SDAT,
  output logic [ADC_DATA_W-1:0] sample,
  output logic [ADC_CH_W-1:0]   sample_ch,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0]    BIT_LAST = 4'(ADC_FRAME_BITS - 1);

  adc_state_t                state;
  logic [DW-1:0]             div_cnt;
  logic                      div_done;
  logic [3:0]                bit_cnt;
  logic [ADC_FRAME_BITS-1:0] cmd;
  logic [ADC_DATA_W-1:0]     shreg;
  logic [ADC_CH_W-1:0]       cur_addr, last_addr, scan_ptr;
  logic                      discard;
  logic                      tick;

  adc_rate_timer #(.SAMPLE_DIV(SAMPLE_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign div_done = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      cmd          <= '0;
      shreg        <= '0;
      cur_addr     <= '0;
      last_addr    <= '0;
      scan_ptr     <= '0;
      discard      <= 1'b1;
      ADC_SCLK     <= 1'b1;
      ADC_CS_N     <= 1'b1;
      ADC_SADDR    <= 1'b0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      else if (clr_overrun)      overrun <= 1'b0;
      div_cnt <= div_done ? '0 : div_cnt + 1'b1;

      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (!en) discard <= 1'b1;
          if (tick) begin
            state    <= SETUP;
            busy     <= 1'b1;
            ADC_CS_N <= 1'b0;
            if (cfg_scan) begin
              cur_addr <= scan_ptr;
              cmd      <= adc_cmd(scan_ptr);
              scan_ptr <= (scan_ptr >= cfg_scan_last) ? '0 : scan_ptr + 1'b1;
            end else begin
              cur_addr <= cfg_ch;
              cmd      <= adc_cmd(cfg_ch);
            end
          end
        end
        SETUP: if (div_done) begin
          state     <= SHIFT;
          bit_cnt   <= '0;
          ADC_SCLK  <= 1'b0;
          ADC_SADDR <= cmd[ADC_FRAME_BITS-1];
          cmd       <= {cmd[ADC_FRAME_BITS-2:0], 1'b0};
        end
        SHIFT: if (div_done) begin
          // Only the last 12 captures survive in shreg, i.e. periods 5..16.
          if (!ADC_SCLK) begin
            ADC_SCLK <= 1'b1;
            shreg    <= {shreg[ADC_DATA_W-2:0], ADC_SDAT};
          end else if (bit_cnt == BIT_LAST) begin
            state     <= HOLD;
            ADC_CS_N  <= 1'b1;
            ADC_SADDR <= 1'b0;
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            ADC_SCLK  <= 1'b0;
            ADC_SADDR <= cmd[ADC_FRAME_BITS-1];
            cmd       <= {cmd[ADC_FRAME_BITS-2:0], 1'b0};
          end
        end
        HOLD: if (div_done) begin
          state     <= IDLE;
          busy      <= 1'b0;
          discard   <= 1'b0;
          last_addr <= cur_addr;
          // The ADC answers with the conversion for the address of the previous frame.
          if (!discard) begin
            sample_valid <= 1'b1;
            sample       <= shreg;
            sample_ch    <= last_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
